// File: rtl/interp_dac_out_if.sv
// Sample-in / DAC-out bundle for the interpolating DAC output stage.
// The master side drives samples and control; the slave side returns DAC data and flags.
interface interp_dac_out_if #(
  parameter int unsigned DIN_WIDTH  = 14,
  parameter int unsigned DAC_WIDTH  = 14,
  parameter int unsigned GAIN_WIDTH = 16
) ();
  logic signed [DIN_WIDTH-1:0]  din;
  logic                         din_valid;
  logic                         bypass;
  logic signed [GAIN_WIDTH-1:0] gain;
  logic signed [DAC_WIDTH-1:0]  offset;
  logic                         clr_flags;
  logic signed [DAC_WIDTH-1:0]  dac_data;
  logic                         dac_valid;
  logic                         sat_flag;
  logic [15:0]                  early_cnt;

  modport master (
    output din, din_valid, bypass, gain, offset, clr_flags,
    input  dac_data, dac_valid, sat_flag, early_cnt
  );

  modport slave (
    input  din, din_valid, bypass, gain, offset, clr_flags,
    output dac_data, dac_valid, sat_flag, early_cnt
  );
endinterface

// File: rtl/interp_dac_out.sv
// Linear interpolator between decimated samples, followed by a signed gain/offset
// stage with saturation to the DAC range. One DAC word per clock.
module interp_dac_out #(
  parameter int unsigned DIN_WIDTH   = 14,
  parameter int unsigned DAC_WIDTH   = 14,
  parameter int unsigned INTERP_LOG2 = 4,
  parameter int unsigned GAIN_WIDTH  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  interp_dac_out_if.slave  bus
);

  localparam int unsigned S       = INTERP_LOG2;
  localparam int unsigned L       = 1 << S;
  localparam int unsigned ACC_W   = DIN_WIDTH + S + 1;
  localparam int unsigned DELTA_W = DIN_WIDTH + 1;
  localparam int unsigned K_W     = S + 1;
  localparam int unsigned P_W     = DIN_WIDTH + GAIN_WIDTH;
  localparam int unsigned SH      = GAIN_WIDTH - 2 + DIN_WIDTH - DAC_WIDTH;
  localparam int unsigned R_W     = P_W - SH + 1;

  localparam logic signed [DAC_WIDTH-1:0] D_MAX = {1'b0, {(DAC_WIDTH-1){1'b1}}};
  localparam logic signed [DAC_WIDTH-1:0] D_MIN = {1'b1, {(DAC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RAMP, HOLD} state_t;

  state_t                     state_q, state_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [DELTA_W-1:0]  delta_q, delta_d, delta_new;
  logic [K_W-1:0]             k_q, k_d;
  logic                       early_inc;
  logic signed [DIN_WIDTH-1:0] y;

  logic signed [P_W-1:0]       p_q, p_d;
  logic                        y_valid, p_valid;
  logic signed [R_W-1:0]       r;
  logic signed [DAC_WIDTH-1:0] dac_d;
  logic                        clip;

  // y is the floor of acc with S fractional bits dropped
  assign y         = DIN_WIDTH'(acc_q >>> S);
  assign delta_new = DELTA_W'(bus.din) - DELTA_W'(y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Segment control: a new sample always restarts the ramp from the current y
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    delta_d   = delta_q;
    k_d       = k_q;
    early_inc = 1'b0;
    if (bus.bypass) begin
      state_d = HOLD;
      if (bus.din_valid) acc_d = ACC_W'(bus.din) <<< S;
    end else begin
      unique case (state_q)
        IDLE, HOLD: begin
          if (bus.din_valid) begin
            state_d = RAMP;
            delta_d = delta_new;
            acc_d   = (ACC_W'(y) <<< S) + ACC_W'(delta_new);
            k_d     = K_W'(1);
          end
        end
        RAMP: begin
          if (bus.din_valid) begin
            delta_d   = delta_new;
            acc_d     = (ACC_W'(y) <<< S) + ACC_W'(delta_new);
            k_d       = K_W'(1);
            early_inc = (k_q < K_W'(L));
          end else if (k_q == K_W'(L)) begin
            state_d = HOLD;
          end else begin
            acc_d = acc_q + ACC_W'(delta_q);
            k_d   = k_q + K_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      delta_q <= '0;
      k_q     <= '0;
    end else begin
      acc_q   <= acc_d;
      delta_q <= delta_d;
      k_q     <= k_d;
    end
  end

  // Gain product, then scale, offset and clamp to the DAC range
  assign p_d = P_W'(y) * P_W'(bus.gain);

  always_comb begin
    r     = R_W'(p_q >>> SH) + R_W'(bus.offset);
    clip  = 1'b0;
    dac_d = DAC_WIDTH'(r);
    if (r > R_W'(D_MAX)) begin
      dac_d = D_MAX;
      clip  = 1'b1;
    end else if (r < R_W'(D_MIN)) begin
      dac_d = D_MIN;
      clip  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q           <= '0;
      y_valid       <= 1'b0;
      p_valid       <= 1'b0;
      bus.dac_data  <= '0;
      bus.dac_valid <= 1'b0;
      bus.sat_flag  <= 1'b0;
      bus.early_cnt <= '0;
    end else begin
      y_valid       <= y_valid | bus.din_valid;
      p_valid       <= y_valid;
      p_q           <= p_d;
      bus.dac_data  <= dac_d;
      bus.dac_valid <= p_valid;
      if (clip)               bus.sat_flag <= 1'b1;
      else if (bus.clr_flags) bus.sat_flag <= 1'b0;
      // A coinciding increment beats the clear
      if (early_inc) begin
        if (bus.clr_flags)                  bus.early_cnt <= 16'd1;
        else if (bus.early_cnt != 16'hFFFF) bus.early_cnt <= bus.early_cnt + 16'd1;
      end else if (bus.clr_flags) begin
        bus.early_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_interp_dac_out.sv
// Scoreboard bench for interp_dac_out: stimulus queues the expected DAC word for
// every y produced, a negedge monitor pops and compares whenever dac_valid is high.
module tb_interp_dac_out;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  interp_dac_out_if bus ();
  interp_dac_out dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    bit chk;
    int val;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks  = 0;
  int   passes  = 0;
  bit   started = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // One clock; queue the expected DAC word for the y that this edge produces
  task automatic tick(input bit chk, input int val);
    exp_t e;
    if (bus.din_valid) started = 1'b1;
    @(posedge clk);
    #1;
    if (started) begin
      e.chk = chk;
      e.val = val;
      q.push_back(e);
    end
  endtask

  // Valid sample followed by the rest of its segment: y = y0 + step*i, i = 1..n
  task automatic seg(input int d, input int y0, input int step, input int n, input bit chk);
    bus.din       = 14'(d);
    bus.din_valid = 1'b1;
    tick(chk, y0 + step);
    bus.din_valid = 1'b0;
    for (int i = 2; i <= n; i++) tick(chk, y0 + step * i);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.dac_valid) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL scoreboard_underflow: got dac_data %0d with no expected entry", bus.dac_data);
      end else begin
        mon_e = q.pop_front();
        if (mon_e.chk) check("dac_data", int'(bus.dac_data), mon_e.val);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget, got timeout required finish");
    $fatal(1);
  end

  initial begin
    bus.din       = '0;
    bus.din_valid = 1'b0;
    bus.bypass    = 1'b0;
    bus.gain      = 16'sd16384;
    bus.offset    = '0;
    bus.clr_flags = 1'b0;
    #2;
    check("rst_dac_data",  int'(bus.dac_data),  0);
    check("rst_dac_valid", int'(bus.dac_valid), 0);
    check("rst_sat_flag",  int'(bus.sat_flag),  0);
    check("rst_early_cnt", int'(bus.early_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(0, 0);

    // Ramp up 0 -> 1600, step 100, with dac_valid latency
    bus.din = 14'sd1600;
    bus.din_valid = 1'b1;
    tick(1, 100);
    bus.din_valid = 1'b0;
    check("dac_valid_lat1", int'(bus.dac_valid), 0);
    tick(1, 200);
    check("dac_valid_lat2", int'(bus.dac_valid), 0);
    tick(1, 300);
    check("dac_valid_lat3", int'(bus.dac_valid), 1);
    for (int i = 4; i <= 16; i++) tick(1, 100 * i);
    tick(1, 1600);
    tick(1, 1600);

    // Ramp down 1600 -> -1600, step -200
    seg(-1600, 1600, -200, 16, 1);
    check("early_cnt_ramp_down", int'(bus.early_cnt), 0);
    tick(1, -1600);
    tick(1, -1600);

    // Back to 0, then early sample at k=8 (y=800) with clr_flags coinciding
    seg(0, -1600, 100, 16, 1);
    tick(1, 0);
    seg(1600, 0, 100, 8, 1);
    bus.din       = '0;
    bus.din_valid = 1'b1;
    bus.clr_flags = 1'b1;
    tick(1, 750);
    bus.din_valid = 1'b0;
    bus.clr_flags = 1'b0;
    check("early_cnt_inc_wins", int'(bus.early_cnt), 1);
    for (int i = 2; i <= 16; i++) tick(1, 800 - 50 * i);
    // Valid exactly when k reaches L is not early
    seg(320, 0, 20, 16, 1);
    check("early_cnt_boundary", int'(bus.early_cnt), 1);
    check("sat_flag_clean", int'(bus.sat_flag), 0);

    // Saturation with gain 32767, ramp 320 -> 8000
    tick(1, 320);
    tick(0, 0);
    tick(0, 0);
    bus.gain = 16'sd32767;
    seg(8000, 320, 480, 16, 0);
    tick(1, 8191);
    tick(1, 8191);
    tick(1, 8191);
    check("sat_flag_set", int'(bus.sat_flag), 1);

    // Clip-free again, then clear
    tick(0, 0);
    tick(0, 0);
    bus.gain = 16'sd16384;
    tick(1, 8000);
    tick(1, 8000);
    tick(1, 8000);
    bus.clr_flags = 1'b1;
    tick(1, 8000);
    bus.clr_flags = 1'b0;
    check("sat_flag_clr", int'(bus.sat_flag), 0);
    check("early_cnt_clr", int'(bus.early_cnt), 0);

    // First clip lands on the same edge as clr_flags
    tick(0, 0);
    tick(0, 0);
    bus.gain = 16'sd32767;
    tick(0, 0);
    bus.clr_flags = 1'b1;
    tick(0, 0);
    bus.clr_flags = 1'b0;
    check("sat_flag_set_wins", int'(bus.sat_flag), 1);

    // Restore unity gain and clear before bypass
    bus.gain = 16'sd16384;
    tick(1, 8000);
    tick(1, 8000);
    tick(1, 8000);
    bus.clr_flags = 1'b1;
    tick(1, 8000);
    bus.clr_flags = 1'b0;
    check("sat_flag_clr2", int'(bus.sat_flag), 0);

    // Bypass: y jumps straight to din
    bus.bypass    = 1'b1;
    bus.din       = -14'sd5000;
    bus.din_valid = 1'b1;
    tick(1, -5000);
    bus.din_valid = 1'b0;
    tick(1, -5000);
    tick(1, -5000);
    check("sat_flag_bypass", int'(bus.sat_flag), 0);
    tick(0, 0);
    tick(0, 0);
    bus.offset = -14'sd5000;
    tick(1, -8192);
    tick(1, -8192);
    tick(1, -8192);
    check("sat_flag_offset", int'(bus.sat_flag), 1);

    // Reset in the middle of a ramp (k=5)
    tick(0, 0);
    tick(0, 0);
    bus.offset = '0;
    bus.bypass = 1'b0;
    seg(0, 0, 0, 5, 0);
    #3;
    rst_n = 1'b0;
    started = 1'b0;
    q.delete();
    #1;
    check("midramp_rst_dac_data",  int'(bus.dac_data),  0);
    check("midramp_rst_dac_valid", int'(bus.dac_valid), 0);
    check("midramp_rst_sat_flag",  int'(bus.sat_flag),  0);
    check("midramp_rst_early_cnt", int'(bus.early_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(0, 0);
    bus.din = 14'sd320;
    bus.din_valid = 1'b1;
    tick(1, 20);
    bus.din_valid = 1'b0;
    check("dac_valid_after_rst", int'(bus.dac_valid), 0);
    for (int i = 2; i <= 16; i++) tick(1, 20 * i);
    tick(1, 320);
    tick(1, 320);
    tick(1, 320);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/interp_dac_out.md
Name: interp_dac_out

Overview:
Output stage placed directly downstream of the BRAM waveform reader. It takes the decimated sample stream and linearly interpolates between successive samples over 2^INTERP_LOG2 clocks. It then applies a signed gain and offset and saturates to the 14-bit DAC range. The result drives the DAC data bus once per clock.

Parameters:
DIN_WIDTH, 14, signed input sample width; must be >= DAC_WIDTH
DAC_WIDTH, 14, signed DAC output width
INTERP_LOG2, 4, log2 of the interpolation length L (clocks per segment); set equal to the upstream dec_rate
GAIN_WIDTH, 16, signed gain width; fixed-point with GAIN_WIDTH-2 fractional bits (1.0 = 16384 at default)

Ports:
clk  in  1  system clock, shared with the BRAM reader
rst_n  in  1  asynchronous, active-low reset
din  in  DIN_WIDTH  signed sample from the BRAM reader
din_valid  in  1  one-cycle strobe marking a new din; no backpressure
bypass  in  1  1: no interpolation, y follows din on each din_valid
gain  in  GAIN_WIDTH  signed gain
offset  in  DAC_WIDTH  signed offset added after the gain
clr_flags  in  1  clears sat_flag and early_cnt
dac_data  out  DAC_WIDTH  signed, saturated output sample
dac_valid  out  1  high once the pipeline holds real data
sat_flag  out  1  sticky; set when any output sample was clipped
early_cnt  out  16  count of samples that arrived before their segment completed; saturates at 0xFFFF

Behaviour:
- Reset (asynchronous, rst_n=0):
  - acc, y, step counter k, all pipeline registers, dac_data, dac_valid, sat_flag and early_cnt go to 0.
  - FSM goes to IDLE.
  - Reset asserted mid-ramp aborts the ramp immediately.
- Interpolator datapath:
  - acc is signed, DIN_WIDTH+INTERP_LOG2+1 bits, with S=INTERP_LOG2 fractional bits.
  - y = acc >>> S (floor); y is registered and DIN_WIDTH wide.
- FSM states:
  - IDLE (acc=0). On din_valid -> RAMP.
  - RAMP:
    - On entry: delta <= din - y (DIN_WIDTH+1 bits, y taken in the valid cycle); acc <= (y<<S) + delta; k <= 1.
    - Each following cycle: acc += delta, k++.
    - When k==L, acc equals din<<S exactly -> HOLD.
  - HOLD: acc constant. On din_valid -> RAMP.
- Output of a ramp:
  - The first y after a valid is y0 + floor(delta/L).
  - The L-th y equals din exactly.
- Early sample:
  - din_valid in RAMP with k<L restarts the segment from the current y (same entry actions) and increments early_cnt.
  - A valid in the same cycle that k reaches L is not early.
- Bypass:
  - bypass=1: on din_valid, acc <= din<<S (y=din next cycle); k is not used; FSM sits in HOLD.
  - Switching bypass mid-ramp freezes acc at its current value.
- Gain/offset stage (2 registered stages):
  - Stage 1: p = y*gain (DIN_WIDTH+GAIN_WIDTH bits, signed).
  - Stage 2: r = (p >>> (GAIN_WIDTH-2+DIN_WIDTH-DAC_WIDTH)) + sign-extended offset, computed with 2 guard bits. Truncation (floor), no rounding.
  - r is clamped to [-2^(DAC_WIDTH-1), 2^(DAC_WIDTH-1)-1] = [-8192, 8191].
  - A clamp sets sat_flag.
- Latency:
  - y appears 1 cycle after din_valid.
  - dac_data reflects y 2 cycles later, i.e. 3 cycles after din_valid.
  - dac_valid rises with the first real sample (3 cycles after the first din_valid after reset) and stays high until reset.
- Flags:
  - clr_flags clears sat_flag and early_cnt.
  - If a set/increment coincides with clr_flags, the set wins: sat_flag=1, early_cnt=1.
- gain and offset are sampled every cycle; changes take effect at the next pipeline pass.

Test Plan:
1. Ramp up (gain=16384, offset=0): reset, then din=1600 valid -> y=100,200,...,1600 over 16 cycles, then holds; dac_data follows 2 cycles behind y; dac_valid rises 3 cycles after the valid.
2. Ramp down: from 1600, din=-1600 valid -> step -200 per cycle; reaches -1600 on cycle 16 and holds; early_cnt=0.
3. Early sample: din=1600, then din=0 valid at k=8 (y=800) -> new ramp 750,700,...,0; early_cnt=1. Valid exactly at k=16 -> early_cnt unchanged.
4. Saturation: gain=32767, din=8000 -> after ramp, dac_data=8191 (raw 15999) and sat_flag=1. Set clamp-free conditions and pulse clr_flags -> sat_flag=0. Clip in the same cycle as clr_flags -> sat_flag stays 1.
5. Bypass: bypass=1, offset=0, din=-5000 valid -> y=-5000 next cycle, dac_data=-5000. Then offset=-5000 -> dac_data=-8192 and sat_flag=1.
6. Reset mid-ramp: drop rst_n at k=5 -> all outputs 0 immediately, without waiting for a clock edge. After release, din=320 valid -> ramp 20,40,...,320 from 0.
